// File: rtl/display_scan_capture_if.sv
// Bus between the 7-segment scan driver side and the read-back capture block.
// The scan side (master) drives anodes/cathodes; the capture side (slave) returns decoded frames.
interface display_scan_capture_if;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  invalid;
    logic        frame_valid;
    logic        scan_err;
    logic        stalled;

    modport master (
        output an, seg,
        input  digits, blank, invalid, frame_valid, scan_err, stalled
    );

    modport slave (
        input  an, seg,
        output digits, blank, invalid, frame_valid, scan_err, stalled
    );
endinterface

// File: rtl/display_scan_capture.sv
// Watches the multiplexed active-low 7-segment bus, samples each settled dwell,
// decodes it to hex and publishes coherent 4-digit frames with a one-cycle strobe.
module display_scan_capture #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STALL_CYCLES  = 65535
) (
    input logic                   clk,
    input logic                   rst_n,
    display_scan_capture_if.slave bus
);

    localparam int unsigned STAB_W  = 8;
    localparam int unsigned STALL_W = 20;

    typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_COMMIT} state_t;

    state_t               r_state;
    logic [3:0]           r_an_q;
    logic [6:0]           r_seg_q;
    logic [10:0]          r_prev;
    logic [STAB_W-1:0]    r_stab_cnt;
    logic                 r_sampled;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [1:0]           r_expect;
    logic [15:0]          r_sh_dig;
    logic [3:0]           r_sh_blank;
    logic [3:0]           r_sh_inv;
    logic [15:0]          r_digits;
    logic [3:0]           r_blank;
    logic [3:0]           r_invalid;
    logic                 r_frame_valid;
    logic                 r_scan_err;
    logic                 r_stalled;

    logic                 w_legal;
    logic [1:0]           w_idx;
    logic                 w_stable;
    logic [STAB_W-1:0]    w_stab_inc;
    logic                 w_sample;
    logic [STALL_W-1:0]   w_stall_nxt;
    logic [3:0]           w_nib;
    logic                 w_blank;
    logic                 w_inv;

    // Dwell legality, settle tracking and the one-shot sample decision
    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (r_an_q)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
        w_stable    = w_legal && ({r_an_q, r_seg_q} == r_prev);
        w_stab_inc  = (r_stab_cnt == {STAB_W{1'b1}}) ? r_stab_cnt : r_stab_cnt + STAB_W'(1);
        w_sample    = w_stable && !r_sampled && (w_stab_inc >= STAB_W'(SETTLE_CYCLES));
        w_stall_nxt = w_sample ? '0 :
                      (r_stall_cnt == {STALL_W{1'b1}}) ? r_stall_cnt : r_stall_cnt + STALL_W'(1);
    end

    // Glyph decode of the registered cathodes
    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b0;
        w_inv   = 1'b0;
        case (r_seg_q)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            7'h7F: w_blank = 1'b1;
            default: w_inv = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_HUNT;
            r_an_q        <= 4'hF;
            r_seg_q       <= 7'h7F;
            r_prev        <= 11'h7FF;
            r_stab_cnt    <= '0;
            r_sampled     <= 1'b0;
            r_stall_cnt   <= '0;
            r_expect      <= 2'd0;
            r_sh_dig      <= '0;
            r_sh_blank    <= '0;
            r_sh_inv      <= '0;
            r_digits      <= '0;
            r_blank       <= '0;
            r_invalid     <= '0;
            r_frame_valid <= 1'b0;
            r_scan_err    <= 1'b0;
            r_stalled     <= 1'b0;
        end else begin
            r_an_q        <= bus.an;
            r_seg_q       <= bus.seg;
            r_prev        <= {r_an_q, r_seg_q};
            r_frame_valid <= 1'b0;
            r_stall_cnt   <= w_stall_nxt;
            r_stalled     <= (w_stall_nxt >= STALL_W'(STALL_CYCLES));

            if (!w_stable) begin
                r_stab_cnt <= '0;
                r_sampled  <= 1'b0;
            end else begin
                r_stab_cnt <= w_stab_inc;
                if (w_sample) r_sampled <= 1'b1;
            end

            // Samples land in the shadow frame; only complete 0..3 runs are published
            case (r_state)
                S_HUNT: begin
                    if (w_sample && w_idx == 2'd0) begin
                        r_sh_dig[{w_idx, 2'b00} +: 4] <= w_nib;
                        r_sh_blank[w_idx]             <= w_blank;
                        r_sh_inv[w_idx]               <= w_inv;
                        r_expect                      <= 2'd1;
                        r_state                       <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_sample) begin
                        if (w_idx == r_expect) begin
                            r_sh_dig[{w_idx, 2'b00} +: 4] <= w_nib;
                            r_sh_blank[w_idx]             <= w_blank;
                            r_sh_inv[w_idx]               <= w_inv;
                            r_expect                      <= r_expect + 2'd1;
                            if (w_idx == 2'd3) r_state <= S_COMMIT;
                        end else begin
                            r_scan_err <= 1'b1;
                            if (w_idx == 2'd0) begin
                                r_sh_dig[{w_idx, 2'b00} +: 4] <= w_nib;
                                r_sh_blank[w_idx]             <= w_blank;
                                r_sh_inv[w_idx]               <= w_inv;
                                r_expect                      <= 2'd1;
                            end else begin
                                r_state <= S_HUNT;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    r_digits      <= r_sh_dig;
                    r_blank       <= r_sh_blank;
                    r_invalid     <= r_sh_inv;
                    r_frame_valid <= 1'b1;
                    r_expect      <= 2'd0;
                    r_state       <= S_COLLECT;
                    // A digit-0 sample arriving alongside the commit starts the next frame
                    if (w_sample) begin
                        if (w_idx == 2'd0) begin
                            r_sh_dig[{w_idx, 2'b00} +: 4] <= w_nib;
                            r_sh_blank[w_idx]             <= w_blank;
                            r_sh_inv[w_idx]               <= w_inv;
                            r_expect                      <= 2'd1;
                        end else begin
                            r_scan_err <= 1'b1;
                            r_state    <= S_HUNT;
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign bus.digits      = r_digits;
    assign bus.blank       = r_blank;
    assign bus.invalid     = r_invalid;
    assign bus.frame_valid = r_frame_valid;
    assign bus.scan_err    = r_scan_err;
    assign bus.stalled     = r_stalled;

endmodule

// File: tb/tb_display_scan_capture.sv
// Directed bench for display_scan_capture: drives scan sequences on the falling edge
// and checks frames, flags and timing against hand-computed values.
module tb_display_scan_capture;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   fv_cnt   = 0;
    int   fv_base  = 0;

    always #5 clk = ~clk;

    display_scan_capture_if bus ();

    display_scan_capture #(
        .SETTLE_CYCLES (4),
        .STALL_CYCLES  (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Strobe counter: frame_valid is read before the edge updates it
    always @(posedge clk) if (bus.frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        step(n);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        dwell(4'b1110, s0, 8);
        dwell(4'b1101, s1, 8);
        dwell(4'b1011, s2, 8);
        dwell(4'b0111, s3, 8);
    endtask

    initial begin
        // Reset with digit 2 already on the bus (mid-scan start)
        rst_n   = 1'b0;
        bus.an  = 4'b1011;
        bus.seg = 7'h30;
        step(3);
        chk("rst_digits",  32'(bus.digits), 32'h0);
        chk("rst_blank",   32'(bus.blank), 32'h0);
        chk("rst_invalid", 32'(bus.invalid), 32'h0);
        chk("rst_fv",      32'(bus.frame_valid), 32'h0);
        chk("rst_scanerr", 32'(bus.scan_err), 32'h0);
        chk("rst_stalled", 32'(bus.stalled), 32'h0);

        fv_base = fv_cnt;
        rst_n   = 1'b1;
        step(8);
        dwell(4'b0111, 7'h19, 8);
        chk("midscan_no_frame", 32'(fv_cnt - fv_base), 32'd0);

        // First full frame with exact commit latency
        dwell(4'b1110, 7'h79, 8);
        dwell(4'b1101, 7'h24, 8);
        dwell(4'b1011, 7'h30, 8);
        bus.an  = 4'b0111;
        bus.seg = 7'h19;
        step(6);
        chk("fv_before_commit",     32'(bus.frame_valid), 32'h0);
        chk("digits_before_commit", 32'(bus.digits), 32'h0);
        step(1);
        chk("fv_latency",   32'(bus.frame_valid), 32'h1);
        chk("first_digits", 32'(bus.digits), 32'h4321);
        step(1);
        chk("fv_one_cycle",  32'(bus.frame_valid), 32'h0);
        chk("first_count",   32'(fv_cnt - fv_base), 32'd1);
        chk("first_scanerr", 32'(bus.scan_err), 32'h0);

        // Normal scan: one strobe per 32 clocks
        fv_base = fv_cnt;
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("norm_count",   32'(fv_cnt - fv_base), 32'd2);
        chk("norm_digits",  32'(bus.digits), 32'h4321);
        chk("norm_blank",   32'(bus.blank), 32'h0);
        chk("norm_invalid", 32'(bus.invalid), 32'h0);
        chk("norm_scanerr", 32'(bus.scan_err), 32'h0);

        // Blank and invalid glyphs
        fv_base = fv_cnt;
        frame(7'h40, 7'h7F, 7'h02, 7'h55);
        chk("bi_count",   32'(fv_cnt - fv_base), 32'd1);
        chk("bi_digits",  32'(bus.digits), 32'h0600);
        chk("bi_blank",   32'(bus.blank), 32'h2);
        chk("bi_invalid", 32'(bus.invalid), 32'h8);

        // Remaining glyph decodes
        frame(7'h12, 7'h02, 7'h78, 7'h00);
        chk("dec_5678", 32'(bus.digits), 32'h8765);
        chk("dec_inv_clear", 32'(bus.invalid), 32'h0);
        frame(7'h10, 7'h08, 7'h03, 7'h46);
        chk("dec_9abc", 32'(bus.digits), 32'hCBA9);
        frame(7'h21, 7'h06, 7'h0E, 7'h00);
        chk("dec_def8", 32'(bus.digits), 32'h8FED);
        chk("dec_blank", 32'(bus.blank), 32'h0);

        // One-clock seg glitch inside an 8-clock digit-0 dwell
        fv_base = fv_cnt;
        dwell(4'b1110, 7'h40, 2);
        dwell(4'b1110, 7'h41, 1);
        dwell(4'b1110, 7'h40, 5);
        dwell(4'b1101, 7'h79, 8);
        dwell(4'b1011, 7'h24, 8);
        dwell(4'b0111, 7'h30, 8);
        chk("glitch_count",   32'(fv_cnt - fv_base), 32'd1);
        chk("glitch_digits",  32'(bus.digits), 32'h3210);
        chk("glitch_scanerr", 32'(bus.scan_err), 32'h0);

        // Short dwell on digit 2 breaks the frame
        fv_base = fv_cnt;
        dwell(4'b1110, 7'h79, 8);
        dwell(4'b1101, 7'h24, 8);
        dwell(4'b1011, 7'h30, 3);
        dwell(4'b0111, 7'h19, 8);
        chk("short_scanerr", 32'(bus.scan_err), 32'h1);
        chk("short_count",   32'(fv_cnt - fv_base), 32'd0);
        chk("short_hold",    32'(bus.digits), 32'h3210);
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("recover_count",  32'(fv_cnt - fv_base), 32'd1);
        chk("recover_digits", 32'(bus.digits), 32'h4321);

        // Stall: last sample was two edges ago
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        step(97);
        chk("stall_pre", 32'(bus.stalled), 32'h0);
        step(1);
        chk("stall_set",    32'(bus.stalled), 32'h1);
        chk("stall_digits", 32'(bus.digits), 32'h4321);
        bus.an  = 4'b1110;
        bus.seg = 7'h40;
        step(5);
        chk("stall_hold", 32'(bus.stalled), 32'h1);
        step(1);
        chk("stall_clear", 32'(bus.stalled), 32'h0);
        step(2);
        dwell(4'b1101, 7'h79, 8);

        // Reset after digits 0 and 1 were captured
        rst_n = 1'b0;
        step(1);
        chk("mrst_digits",  32'(bus.digits), 32'h0);
        chk("mrst_scanerr", 32'(bus.scan_err), 32'h0);
        chk("mrst_stalled", 32'(bus.stalled), 32'h0);
        chk("mrst_fv",      32'(bus.frame_valid), 32'h0);
        fv_base = fv_cnt;
        step(1);
        rst_n = 1'b1;
        dwell(4'b1011, 7'h30, 8);
        dwell(4'b0111, 7'h19, 8);
        chk("mrst_no_partial", 32'(fv_cnt - fv_base), 32'd0);
        chk("mrst_digits_hold", 32'(bus.digits), 32'h0);
        frame(7'h40, 7'h79, 7'h24, 7'h30);
        chk("mrst_count",   32'(fv_cnt - fv_base), 32'd1);
        chk("mrst_frame",   32'(bus.digits), 32'h3210);
        chk("mrst_err_end", 32'(bus.scan_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
